// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI responder.
package spi_pkg;

    localparam int unsigned SPI_WORD_W = 8;
    localparam int unsigned SPI_CNT_W  = $clog2(SPI_WORD_W + 1);

    typedef logic [SPI_WORD_W-1:0] spi_word_t;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the local transmit/receive ports of the responder.
interface spi_slave_if;
    import spi_pkg::*;

    logic      sck;
    logic      cs_n;
    logic      mosi;
    logic      miso;
    logic      miso_oe;
    spi_word_t txData;
    logic      txValid;
    logic      txReady;
    spi_word_t rxData;
    logic      rxValid;
    logic      txUnderrun;
    logic      busy;

    modport slave (
        input  sck, cs_n, mosi, txData, txValid,
        output miso, miso_oe, txReady, rxData, rxValid, txUnderrun, busy
    );

    modport master (
        output sck, cs_n, mosi, txData, txValid,
        input  miso, miso_oe, txReady, rxData, rxValid, txUnderrun, busy
    );
endinterface

// File: rtl/spi_sync.sv
// Two-flop synchroniser for an asynchronous pin, with edge detect on the synced level.
module spi_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [1:0] sync_q;
    logic       dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], d};
            dly_q  <= sync_q[1];
        end
    end

    assign q      = sync_q[1];
    assign rise_c = sync_q[1] & ~dly_q;
    assign fall_c = ~sync_q[1] & dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversampled SCK/CS_n/MOSI, 8-bit shift in/out, holding register for TX.
module spi_slave
    import spi_pkg::*;
#(
    parameter bit        CPOL       = 1'b0,
    parameter bit        CPHA       = 1'b0,
    parameter spi_word_t DEFAULT_TX = 8'hFF
) (
    input logic        clk,
    input logic        rst,
    spi_slave_if.slave bus
);

    localparam int unsigned W = SPI_WORD_W;

    logic sck_rise, sck_fall, cs_q, cs_rise, cs_fall, mosi_q;
    logic unused_sck_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_sync u_sync_sck (
        .clk(clk), .rst(rst), .d(bus.sck),
        .q(unused_sck_lvl), .rise_c(sck_rise), .fall_c(sck_fall)
    );

    spi_sync u_sync_cs (
        .clk(clk), .rst(rst), .d(bus.cs_n),
        .q(cs_q), .rise_c(cs_rise), .fall_c(cs_fall)
    );

    spi_sync u_sync_mosi (
        .clk(clk), .rst(rst), .d(bus.mosi),
        .q(mosi_q), .rise_c(unused_mosi_rise), .fall_c(unused_mosi_fall)
    );

    // Map SCK edges onto sample/shift according to the SPI mode.
    logic lead_c, trail_c, sample_c, shift_c;
    assign lead_c   = CPOL ? sck_fall : sck_rise;
    assign trail_c  = CPOL ? sck_rise : sck_fall;
    assign sample_c = CPHA ? trail_c  : lead_c;
    assign shift_c  = CPHA ? lead_c   : trail_c;

    spi_state_e           state_q, state_d;
    spi_word_t            tx_shift_q, tx_shift_d;
    spi_word_t            rx_shift_q, rx_shift_d;
    spi_word_t            hold_q, hold_d;
    spi_word_t            rx_data_q, rx_data_d;
    logic [SPI_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 tx_underrun_q, tx_underrun_d;
    logic                 busy_q, busy_d;
    logic                 miso_oe_q, miso_oe_d;
    logic                 load_c;
    spi_word_t            rx_word_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_IDLE;
            tx_shift_q    <= DEFAULT_TX;
            rx_shift_q    <= '0;
            hold_q        <= '0;
            rx_data_q     <= '0;
            bit_cnt_q     <= '0;
            tx_ready_q    <= 1'b1;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            busy_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            hold_q        <= hold_d;
            rx_data_q     <= rx_data_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_ready_q    <= tx_ready_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            busy_q        <= busy_d;
            miso_oe_q     <= miso_oe_d;
        end
    end

    // Next-state, shift/count and holding-register logic.
    always_comb begin
        state_d       = state_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        hold_d        = hold_q;
        rx_data_d     = rx_data_q;
        bit_cnt_d     = bit_cnt_q;
        tx_ready_d    = tx_ready_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        busy_d        = busy_q;
        miso_oe_d     = miso_oe_q;
        load_c        = 1'b0;
        rx_word_c     = {rx_shift_q[W-2:0], mosi_q};

        case (state_q)
            WAIT_IDLE: begin
                if (cs_q) state_d = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    busy_d    = 1'b1;
                    miso_oe_d = 1'b1;
                    bit_cnt_d = '0;
                    load_c    = !CPHA;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    bit_cnt_d = '0;
                end else begin
                    if (sample_c) begin
                        rx_shift_d = rx_word_c;
                        if (bit_cnt_q == SPI_CNT_W'(W - 1)) begin
                            rx_data_d  = rx_word_c;
                            rx_valid_d = 1'b1;
                            bit_cnt_d  = CPHA ? '0 : SPI_CNT_W'(W);
                        end else begin
                            bit_cnt_d = bit_cnt_q + SPI_CNT_W'(1);
                        end
                    end
                    if (shift_c) begin
                        if (CPHA ? (bit_cnt_q == '0) : (bit_cnt_q == SPI_CNT_W'(W))) begin
                            load_c = 1'b1;
                            if (!CPHA) bit_cnt_d = '0;
                        end else begin
                            tx_shift_d = {tx_shift_q[W-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase

        // Load sees the pre-cycle holding state; a same-cycle write fills it afterwards.
        if (load_c) begin
            if (!tx_ready_q) begin
                tx_shift_d = hold_q;
                tx_ready_d = 1'b1;
            end else begin
                tx_shift_d    = DEFAULT_TX;
                tx_underrun_d = 1'b1;
            end
        end
        if (bus.txValid && tx_ready_q) begin
            hold_d     = bus.txData;
            tx_ready_d = 1'b0;
        end
    end

    assign bus.miso       = tx_shift_q[W-1];
    assign bus.miso_oe    = miso_oe_q;
    assign bus.txReady    = tx_ready_q;
    assign bus.rxData     = rx_data_q;
    assign bus.rxValid    = rx_valid_q;
    assign bus.txUnderrun = tx_underrun_q;
    assign bus.busy       = busy_q;

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder: the far end of our SPI master link.
- Oversamples SCK, CS_n and MOSI on the system clock, shifts 8-bit words in on MOSI and out on MISO.
- Exposes a valid/ready transmit holding register and a pulse-valid receive port to the local logic.
- Pairs with the master block for loopback and for board-level peripheral emulation.

Parameters:
- CPOL, 0, idle SCK level (0 = idle low).
- CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
- DEFAULT_TX, 8'hFF, word sent when no transmit data is queued.

Ports:
- clk  in  1  system clock; must run at least 8x SCK.
- rst  in  1  synchronous, active-high reset.
- sck  in  1  SPI clock, asynchronous.
- cs_n  in  1  chip select, active low, asynchronous.
- mosi  in  1  master-out data, asynchronous.
- miso  out  1  slave-out data.
- miso_oe  out  1  MISO drive enable; high while selected.
- txData  in  8  next word to transmit.
- txValid  in  1  txData valid.
- txReady  out  1  holding register empty; write accepted when txValid && txReady.
- rxData  out  8  last received word; stable until the next rxValid.
- rxValid  out  1  one-cycle pulse when a full word has been received.
- txUnderrun  out  1  one-cycle pulse when a word load finds the holding register empty.
- busy  out  1  transaction active.

Behaviour:
- Reset values: miso=DEFAULT_TX[7], miso_oe=0, txReady=1, rxData=0, rxValid=0, txUnderrun=0, busy=0, bit count 0, holding register empty, state WAIT_IDLE.
- Input synchronisation: sck, cs_n and mosi each pass through 2-FF synchronisers.
  - Edges are detected from the synchronised value versus a 1-cycle-delayed copy.
  - All edge actions occur in the cycle the edge is detected (3 clk after the pin edge).
- Edge mapping:
  - Leading edge is rising when CPOL=0, falling when CPOL=1.
  - Sample edge is leading when CPHA=0, trailing when CPHA=1; shift edge is the other one.
- State machine:
  - WAIT_IDLE -> IDLE when synced cs_n is high. After reset, a frame already in progress is ignored.
  - IDLE -> ACTIVE on synced cs_n falling. On entry: busy=1, miso_oe=1, bit count=0. If CPHA=0, load a word (see Load).
  - ACTIVE -> IDLE on synced cs_n rising, from any bit position. On exit: busy=0, miso_oe=0, partial RX word discarded (no rxValid), bit count=0.
- Load: the shift register takes the holding register if it is full (holding becomes empty, txReady=1 next cycle). Otherwise it takes DEFAULT_TX and txUnderrun pulses.
- miso is always shift register bit 7, MSB first.
- CPHA=0 timing:
  - Sample edge: rx shift in mosi, bit count +1.
  - Shift edge: tx shift left. If bit count==8 (only reachable on the shift edge after the 8th sample), load the next word instead of shifting and set bit count=0.
- CPHA=1 timing:
  - Leading edge with bit count==0: load.
  - Leading edge otherwise: tx shift left.
  - Trailing edge: rx sample, bit count +1; at 8, wrap to 0.
- Receive completion: on the 8th sample, rxData takes the full word and rxValid pulses in the next clk cycle. Consecutive words each produce exactly one pulse.
- Holding register write:
  - Accepted when txValid && txReady; txReady falls next cycle.
  - A write and a load in the same cycle: the load uses the pre-cycle state. If empty, the load underruns and the write fills the holding register for the following word.
- SCK edges while cs_n is high are ignored. MOSI is sampled only on sample edges.
- rst mid-transfer: everything returns to reset values in the next cycle, and the block re-enters WAIT_IDLE.

Decomposition:
- spi_pkg:
  - state enum (WAIT_IDLE, IDLE, ACTIVE);
  - SPI_WORD_W=8;
  - bit-count width constant.
- Sub-module spi_sync: 2-FF synchroniser plus rise/fall edge detect. Instantiated for sck and cs_n; mosi uses the synchroniser only.

Test Plan:
- CPOL=0/CPHA=0, txData=0x3C written before CS, master sends 0xA5 -> rxData=0xA5 with exactly one rxValid pulse; master reads 0x3C; txReady returns high after the load.
- Nothing written, master sends 0x00 -> master reads 0xFF; one txUnderrun pulse; rxData=0x00.
- Two back-to-back words 0x01 and 0x80; 0x11 preloaded and 0x22 written on txReady -> two rxValid pulses (0x01, 0x80); master reads 0x11, 0x22; no underrun.
- CS deasserted after 5 bits, then a full word 0x5A -> no rxValid for the partial word; then rxValid with 0x5A; busy and miso_oe track CS.
- rst pulsed mid-word with CS held low -> all outputs at reset values; further SCK edges ignored until CS goes high then low; the next word 0x96 is received correctly.
- CPOL=1/CPHA=1 instance, exchange 0xC3 out / 0x3C in -> rxData=0x3C and master reads 0xC3; byte load occurs on the first falling SCK edge.
